// File: rtl/cdns_sdhc_datasync_pkg.sv
// Shared constants and filter state encoding for the SDHC pad-input synchronizer/filter.
package cdns_sdhc_datasync_pkg;

  localparam int NUM_FLOPS_DFLT  = 2;
  localparam int FILT_CNT_W_DFLT = 8;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } filt_state_e;

endpackage

// File: rtl/cdns_sdhc_datasync_cell.sv
// Single async-reset synchronizer flop; the technology-cell swap point for metastability hardening.
module cdns_sdhc_datasync_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= RESET_VAL;
    else          q <= d;
  end

endmodule

// File: rtl/cdns_sdhc_datasync_filt_chan.sv
// One channel: NUM_FLOPS-deep sync chain, qualification counter, filtered level and edge pulses.
module cdns_sdhc_datasync_filt_chan
  import cdns_sdhc_datasync_pkg::*;
#(
  parameter int   NUM_FLOPS   = NUM_FLOPS_DFLT,
  parameter int   FILT_CNT_W  = FILT_CNT_W_DFLT,
  parameter logic RESET_STATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  d_in,
  input  logic [FILT_CNT_W-1:0] filt_len,
  output logic                  d_sync,
  output logic                  d_out,
  output logic                  rise_pulse,
  output logic                  fall_pulse
);

  logic [NUM_FLOPS:0]    chain;
  filt_state_e           state;
  logic [FILT_CNT_W-1:0] cnt;
  logic [FILT_CNT_W-1:0] cnt_nxt;
  logic                  d_out_nxt;
  logic                  rise_nxt;
  logic                  fall_nxt;

  assign chain[0] = d_in;

  for (genvar k = 0; k < NUM_FLOPS; k++) begin : g_sync
    cdns_sdhc_datasync_cell #(
      .RESET_VAL (RESET_STATE)
    ) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (chain[k]),
      .q       (chain[k+1])
    );
  end

  assign d_sync = chain[NUM_FLOPS];

  // State is decoded from the level mismatch, so any agreeing cycle drops back to STABLE.
  always_comb begin
    state     = (d_sync != d_out) ? QUALIFY : STABLE;
    cnt_nxt   = '0;
    d_out_nxt = d_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      QUALIFY: begin
        if (cnt >= filt_len) begin
          d_out_nxt = d_sync;
          rise_nxt  = d_sync;
          fall_nxt  = ~d_sync;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      d_out      <= RESET_STATE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      d_out      <= d_out_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

endmodule

// File: rtl/cdns_sdhc_datasync_filt.sv
// Multi-channel SDHC pad-input synchronizer with glitch filter and edge pulses.
// Optional sticky interrupt status is built when CDNS_SDHC_DATASYNC_FILT_IRQ_EN is defined.
module cdns_sdhc_datasync_filt
  import cdns_sdhc_datasync_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               NUM_FLOPS   = NUM_FLOPS_DFLT,
  parameter logic [WIDTH-1:0] RESET_STATE = {WIDTH{1'b0}},
  parameter int               FILT_CNT_W  = FILT_CNT_W_DFLT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      d_in,
  input  logic [FILT_CNT_W-1:0] filt_len,
  output logic [WIDTH-1:0]      d_sync,
  output logic [WIDTH-1:0]      d_out,
  output logic [WIDTH-1:0]      rise_pulse,
  output logic [WIDTH-1:0]      fall_pulse
`ifdef CDNS_SDHC_DATASYNC_FILT_IRQ_EN
  ,
  input  logic [WIDTH-1:0]      irq_en,
  input  logic [WIDTH-1:0]      irq_clr,
  output logic [WIDTH-1:0]      irq_stat
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    cdns_sdhc_datasync_filt_chan #(
      .NUM_FLOPS   (NUM_FLOPS),
      .FILT_CNT_W  (FILT_CNT_W),
      .RESET_STATE (RESET_STATE[i])
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .d_in       (d_in[i]),
      .filt_len   (filt_len),
      .d_sync     (d_sync[i]),
      .d_out      (d_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

`ifdef CDNS_SDHC_DATASYNC_FILT_IRQ_EN
  // Status is set from the registered pulses, one edge after the pulse; set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_stat <= '0;
    else          irq_stat <= (irq_stat & ~irq_clr) | ((rise_pulse | fall_pulse) & irq_en);
  end
`endif

endmodule

// File: tb/tb_cdns_sdhc_datasync_filt.sv
// Directed bench for cdns_sdhc_datasync_filt with a time-stamped expectation queue.
module tb_cdns_sdhc_datasync_filt;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] d_in;
  logic [7:0] filt_len;
  logic [3:0] d_sync, d_out, rise_pulse, fall_pulse;
  logic [3:0] irq_en, irq_clr, irq_stat;

  always #5 clk = ~clk;

  cdns_sdhc_datasync_filt #(
    .WIDTH       (4),
    .NUM_FLOPS   (2),
    .RESET_STATE (4'b0000),
    .FILT_CNT_W  (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_in       (d_in),
    .filt_len   (filt_len),
    .d_sync     (d_sync),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
`ifdef CDNS_SDHC_DATASYNC_FILT_IRQ_EN
    ,
    .irq_en     (irq_en),
    .irq_clr    (irq_clr),
    .irq_stat   (irq_stat)
`endif
  );

`ifndef CDNS_SDHC_DATASYNC_FILT_IRQ_EN
  assign irq_stat = 4'b0000;
`endif

  // kind: 0 d_sync, 1 d_out, 2 rise_pulse, 3 fall_pulse, 4 irq_stat
  typedef struct {
    int         at;
    int         kind;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   edges;
  int   n_vec;
  int   n_bad;

  function automatic logic [3:0] observe(int kind);
    case (kind)
      0:       return d_sync;
      1:       return d_out;
      2:       return rise_pulse;
      3:       return fall_pulse;
      default: return irq_stat;
    endcase
  endfunction

  task automatic push(int kind, int from, int to, logic [3:0] val, string tag);
    for (int c = from; c <= to; c++) sb.push_back('{c, kind, val, tag});
  endtask

  task automatic push_now(logic [3:0] val, string tag);
    for (int k = 0; k < 4; k++) push(k, edges, edges, val, tag);
  endtask

  task automatic check_due();
    logic [3:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edges) begin
        obs = observe(sb[i].kind);
        n_vec++;
        assert (obs === sb[i].val) else begin
          n_bad++;
          $error("FAIL %s kind%0d @edge%0d: observed %b expected %b",
                 sb[i].tag, sb[i].kind, edges, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edges++;
      check_due();
    end
  endtask

  int e;

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    edges    = 0;
    reset_n  = 1'b0;
    d_in     = 4'b1010;
    filt_len = 8'd3;
    irq_en   = 4'b0000;
    irq_clr  = 4'b0000;

    // Reset held while inputs differ from reset state
    tick(3);
    push_now(4'b0000, "rst_hold");
    push(4, edges, edges, 4'b0000, "rst_irq");
    check_due();

    // Test 1: release, filt_len=3
    reset_n = 1'b1;
    edges   = 0;
    push(0, 1, 1, 4'b0000, "t1_sync_e1");
    push(0, 2, 8, 4'b1010, "t1_sync");
    push(1, 1, 5, 4'b0000, "t1_dout_hold");
    push(1, 6, 8, 4'b1010, "t1_dout");
    push(2, 1, 5, 4'b0000, "t1_rise_quiet");
    push(2, 6, 6, 4'b1010, "t1_rise");
    push(2, 7, 8, 4'b0000, "t1_rise_end");
    push(3, 1, 8, 4'b0000, "t1_no_fall");
    tick(8);

    // Test 2a: 4-cycle glitch on ch0 with filt_len=4 is rejected
    filt_len = 8'd4;
    e = edges;
    push(0, e + 2, e + 5, 4'b1011, "t2a_sync_glitch");
    push(1, e + 1, e + 9, 4'b1010, "t2a_dout");
    push(2, e + 1, e + 9, 4'b0000, "t2a_rise");
    push(3, e + 1, e + 9, 4'b0000, "t2a_fall");
    d_in = 4'b1011;
    tick(4);
    d_in = 4'b1010;
    tick(5);

    // Test 2b: 5-cycle glitch qualifies, then falls 5 cycles after d_sync drops
    e = edges;
    push(1, e + 1,  e + 6,  4'b1010, "t2b_dout_pre");
    push(1, e + 7,  e + 11, 4'b1011, "t2b_dout_hi");
    push(1, e + 12, e + 13, 4'b1010, "t2b_dout_lo");
    push(2, e + 1,  e + 6,  4'b0000, "t2b_rise_pre");
    push(2, e + 7,  e + 7,  4'b0001, "t2b_rise");
    push(2, e + 8,  e + 13, 4'b0000, "t2b_rise_post");
    push(3, e + 1,  e + 11, 4'b0000, "t2b_fall_pre");
    push(3, e + 12, e + 12, 4'b0001, "t2b_fall");
    push(3, e + 13, e + 13, 4'b0000, "t2b_fall_post");
    d_in = 4'b1011;
    tick(5);
    d_in = 4'b1010;
    tick(8);

    // Test 3: filt_len=0, ch2 toggling every 4 cycles
    filt_len = 8'd0;
    e = edges;
    push(0, e + 2,  e + 5,  4'b1110, "t3_sync_hi");
    push(0, e + 6,  e + 9,  4'b1010, "t3_sync_lo");
    push(1, e + 1,  e + 2,  4'b1010, "t3_dout0");
    push(1, e + 3,  e + 6,  4'b1110, "t3_dout1");
    push(1, e + 7,  e + 10, 4'b1010, "t3_dout2");
    push(1, e + 11, e + 14, 4'b1110, "t3_dout3");
    push(1, e + 15, e + 16, 4'b1010, "t3_dout4");
    push(2, e + 1,  e + 2,  4'b0000, "t3_rise_q0");
    push(2, e + 3,  e + 3,  4'b0100, "t3_rise_a");
    push(2, e + 4,  e + 10, 4'b0000, "t3_rise_q1");
    push(2, e + 11, e + 11, 4'b0100, "t3_rise_b");
    push(2, e + 12, e + 16, 4'b0000, "t3_rise_q2");
    push(3, e + 1,  e + 6,  4'b0000, "t3_fall_q0");
    push(3, e + 7,  e + 7,  4'b0100, "t3_fall_a");
    push(3, e + 8,  e + 14, 4'b0000, "t3_fall_q1");
    push(3, e + 15, e + 15, 4'b0100, "t3_fall_b");
    push(3, e + 16, e + 16, 4'b0000, "t3_fall_q2");
    d_in = 4'b1110;
    tick(4);
    d_in = 4'b1010;
    tick(4);
    d_in = 4'b1110;
    tick(4);
    d_in = 4'b1010;
    tick(4);

    // Simultaneous falls on ch1 and ch3
    e = edges;
    push(1, e + 1, e + 2, 4'b1010, "clr_dout_pre");
    push(1, e + 3, e + 4, 4'b0000, "clr_dout");
    push(3, e + 3, e + 3, 4'b1010, "clr_fall_multi");
    push(3, e + 4, e + 4, 4'b0000, "clr_fall_end");
    push(2, e + 1, e + 4, 4'b0000, "clr_no_rise");
    d_in = 4'b0000;
    tick(4);

    // Test 4: filt_len=200, lowered to 10 once cnt reaches 50
    filt_len = 8'd200;
    e = edges;
    push(1, e + 1,  e + 52, 4'b0000, "t4_dout_hold");
    push(1, e + 53, e + 55, 4'b0010, "t4_dout");
    push(2, e + 1,  e + 52, 4'b0000, "t4_rise_quiet");
    push(2, e + 53, e + 53, 4'b0010, "t4_rise");
    push(2, e + 54, e + 55, 4'b0000, "t4_rise_end");
    push(3, e + 1,  e + 55, 4'b0000, "t4_no_fall");
    d_in = 4'b0010;
    tick(52);
    filt_len = 8'd10;
    tick(3);

    // Test 5: reset during ch3 qualification (cnt=2 of 5)
    filt_len = 8'd5;
    e = edges;
    push(1, e + 1, e + 4, 4'b0010, "t5_dout_pre");
    push(2, e + 1, e + 4, 4'b0000, "t5_rise_pre");
    push(3, e + 1, e + 4, 4'b0000, "t5_fall_pre");
    d_in = 4'b1010;
    tick(4);
    reset_n = 1'b0;
    #1;
    push_now(4'b0000, "t5_async_rst");
    check_due();
    e = edges;
    push(1, e + 1, e + 2, 4'b0000, "t5_rst_dout");
    push(2, e + 1, e + 2, 4'b0000, "t5_rst_rise");
    tick(2);
    reset_n = 1'b1;
    e = edges;
    push(0, e + 1, e + 1, 4'b0000, "t5_sync_e1");
    push(0, e + 2, e + 9, 4'b1010, "t5_sync");
    push(1, e + 1, e + 7, 4'b0000, "t5_dout_hold");
    push(1, e + 8, e + 9, 4'b1010, "t5_dout");
    push(2, e + 1, e + 7, 4'b0000, "t5_rise_quiet");
    push(2, e + 8, e + 8, 4'b1010, "t5_rise");
    push(2, e + 9, e + 9, 4'b0000, "t5_rise_end");
    push(3, e + 1, e + 9, 4'b0000, "t5_no_fall");
    tick(9);

`ifdef CDNS_SDHC_DATASYNC_FILT_IRQ_EN
    // Test 6: sticky status, set-wins, enable drop keeps status, lone clear
    irq_en   = 4'b0001;
    filt_len = 8'd0;
    e = edges;
    push(4, e + 1, e + 4, 4'b0000, "t6_irq_masked");
    d_in = 4'b0000;
    tick(4);
    e = edges;
    push(2, e + 3, e + 3, 4'b0011, "t6_rise");
    push(4, e + 1, e + 3, 4'b0000, "t6_irq_pre");
    push(4, e + 4, e + 6, 4'b0001, "t6_irq_set");
    d_in = 4'b0011;
    tick(6);
    e = edges;
    push(3, e + 3, e + 3, 4'b0001, "t6_fall");
    push(4, e + 1, e + 6, 4'b0001, "t6_irq_sticky");
    push(4, e + 7, e + 8, 4'b0000, "t6_irq_cleared");
    d_in = 4'b0010;
    tick(3);
    irq_clr = 4'b0001;
    tick(1);
    irq_clr = 4'b0000;
    irq_en  = 4'b0000;
    tick(2);
    irq_clr = 4'b0001;
    tick(1);
    irq_clr = 4'b0000;
    tick(1);
`endif

    while (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s unchecked @edge%0d: observed none expected %b",
             sb[0].tag, sb[0].at, sb[0].val);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
